// File: rtl/cos_lut_arb_if.sv
// Requester-side bundle for cos_lut_arb: lookup requests in,
// one-hot grants and shared response sample out.
interface cos_lut_arb_if #(
    parameter int N_REQ     = 4,
    parameter int PHI_WIDTH = 10,
    parameter int WIDTH     = 24
);
    logic [N_REQ-1:0]           req_valid;
    logic [N_REQ*PHI_WIDTH-1:0] req_phi;
    logic [N_REQ-1:0]           req_ready;
    logic [N_REQ-1:0]           rsp_valid;
    logic [WIDTH-1:0]           rsp_wav;

    modport master (
        output req_valid,
        output req_phi,
        input  req_ready,
        input  rsp_valid,
        input  rsp_wav
    );

    modport slave (
        input  req_valid,
        input  req_phi,
        output req_ready,
        output rsp_valid,
        output rsp_wav
    );
endinterface

// File: rtl/cos_lut_arb.sv
// Round-robin arbiter sharing one registered cosine LUT between
// N_REQ phase sources; one lookup per cycle, 2-cycle response.
module cos_lut_arb #(
    parameter int N_REQ     = 4,
    parameter int PHI_WIDTH = 10,
    parameter int WIDTH     = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    cos_lut_arb_if.slave         bus,
    output logic [PHI_WIDTH-1:0] lut_phi,
    input  logic [WIDTH-1:0]     lut_wav,
    output logic                 busy
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]        ptr;
    logic [N_REQ-1:0]     tag1;
    logic [N_REQ-1:0]     tag2;
    logic [PHI_WIDTH-1:0] phi_q;

    logic [N_REQ-1:0]     grant;
    logic [PW-1:0]        gidx;
    logic                 found;
    logic [PW:0]          sum;

    logic [PHI_WIDTH-1:0] phi_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign phi_arr[i] = bus.req_phi[i*PHI_WIDTH +: PHI_WIDTH];
    end

    // Pick the first valid requester at or above the pointer, wrapping.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        sum   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N_REQ)) begin
                sum = sum - (PW+1)'(N_REQ);
            end
            if (!found && bus.req_valid[sum[PW-1:0]]) begin
                found                 = 1'b1;
                grant[sum[PW-1:0]]    = 1'b1;
                gidx                  = sum[PW-1:0];
            end
        end
        if (rst) begin
            grant = '0;
            found = 1'b0;
        end
    end

    // Pointer, LUT address and response tag pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            phi_q <= '0;
            tag1  <= '0;
            tag2  <= '0;
        end else begin
            tag1 <= grant;
            tag2 <= tag1;
            if (found) begin
                phi_q <= phi_arr[gidx];
                if (gidx == PW'(N_REQ - 1)) begin
                    ptr <= '0;
                end else begin
                    ptr <= gidx + PW'(1);
                end
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = tag2;
    assign bus.rsp_wav   = lut_wav;
    assign lut_phi       = phi_q;
    assign busy          = (|tag1) | (|tag2);
endmodule

// File: tb/tb_cos_lut_arb.sv
// Directed bench for cos_lut_arb with a registered LUT stand-in
// and a cycle-level reference model of arbitration and latency.
module tb_cos_lut_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  lut_phi;
    logic [23:0] lut_wav;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    int         m_ptr;
    logic [3:0] m_t1, m_t2, last_g;
    logic [9:0] m_p1, m_p2;
    int         n_acc, n_rsp;

    cos_lut_arb_if #(.N_REQ(4), .PHI_WIDTH(10), .WIDTH(24)) bus ();

    cos_lut_arb #(.N_REQ(4), .PHI_WIDTH(10), .WIDTH(24)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .lut_phi (lut_phi),
        .lut_wav (lut_wav),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] lut_fn(input logic [9:0] p);
        return {p, 4'h5, ~p};
    endfunction

    // Stand-in for the registered cos_lut: one cycle read latency.
    always @(posedge clk) lut_wav <= lut_fn(lut_phi);

    function automatic logic [3:0] rr(input logic [3:0] v, input int p);
        logic [3:0] g;
        g = '0;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (p + k) % 4;
            if (g == 4'b0 && v[i]) g[i] = 1'b1;
        end
        return g;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        m_ptr  = 0;
        m_t1   = '0;
        m_t2   = '0;
        m_p1   = '0;
        m_p2   = '0;
        last_g = '0;
    endtask

    task automatic mcheck(input string tag);
        logic [3:0] g;
        g = rr(bus.req_valid, m_ptr);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'(g));
        chk({tag, "_rspv"}, 32'(bus.rsp_valid), 32'(m_t2));
        if (m_t2 != 4'b0) begin
            chk({tag, "_wav"}, 32'(bus.rsp_wav), 32'(lut_fn(m_p2)));
            n_rsp++;
        end
        chk({tag, "_busy"}, 32'(busy), 32'((|m_t1) | (|m_t2)));
        m_t2 = m_t1;
        m_p2 = m_p1;
        m_t1 = g;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) begin
                m_p1  = bus.req_phi[i*10 +: 10];
                m_ptr = (i + 1) % 4;
                n_acc++;
            end
        end
        last_g = g;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag);
        #1;
        mcheck(tag);
        tick();
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
        mreset();
    endtask

    initial begin
        logic [3:0] v;
        int first1;
        int cnt [4];

        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_phi   = '0;
        mreset();
        n_acc = 0;
        n_rsp = 0;
        tick();
        tick();

        // reset: grants forced off, outputs cleared
        bus.req_valid = 4'hF;
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        tick();
        chk("rst_rspv", 32'(bus.rsp_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_lutphi", 32'(lut_phi), 32'h0);
        bus.req_valid = '0;
        rst           = 1'b0;
        mreset();

        // 1: single request from requester 2
        bus.req_phi[20 +: 10] = 10'h100;
        bus.req_valid         = 4'b0100;
        #1;
        chk("t1_ready", 32'(bus.req_ready), 32'h4);
        cyc("t1a");
        chk("t1_lutphi", 32'(lut_phi), 32'h100);
        bus.req_valid = '0;
        cyc("t1b");
        chk("t1_rspv", 32'(bus.rsp_valid), 32'h4);
        chk("t1_wav", 32'(bus.rsp_wav), 32'(lut_fn(10'h100)));
        cyc("t1c");

        // 2: all four valid, round-robin order from pointer 0
        do_reset();
        bus.req_phi   = {10'd40, 10'd30, 10'd20, 10'd10};
        bus.req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t2_grant", 32'(bus.req_ready), 32'(1 << (k % 4)));
            cyc("t2");
        end
        bus.req_valid = '0;
        cyc("t2d0");
        cyc("t2d1");
        cyc("t2d2");

        // 3: fairness with requester 1 joining at cycle 5
        do_reset();
        bus.req_phi   = {10'h333, 10'h222, 10'h111, 10'h0AA};
        bus.req_valid = 4'b1001;
        first1        = -1;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int k = 0; k < 100; k++) begin
            if (k == 5) bus.req_valid[1] = 1'b1;
            cyc("t3");
            for (int i = 0; i < 4; i++) if (last_g[i]) cnt[i]++;
            if (last_g[1] && first1 < 0) first1 = k;
        end
        chk("t3_fair", 32'(first1 >= 5 && first1 <= 8), 32'h1);
        chk("t3_cnt0", 32'(cnt[0] > 0), 32'h1);
        chk("t3_cnt1", 32'(cnt[1] > 0), 32'h1);
        chk("t3_cnt3", 32'(cnt[3] > 0), 32'h1);
        chk("t3_cnt2", 32'(cnt[2]), 32'h0);
        bus.req_valid = '0;
        cyc("t3d0");
        cyc("t3d1");

        // 4: phase wrap 0x3FF then 0x000 back-to-back
        do_reset();
        bus.req_phi[0 +: 10] = 10'h3FF;
        bus.req_valid        = 4'b0001;
        cyc("t4a");
        chk("t4_lutphi0", 32'(lut_phi), 32'h3FF);
        bus.req_phi[0 +: 10] = 10'h000;
        cyc("t4b");
        chk("t4_lutphi1", 32'(lut_phi), 32'h000);
        chk("t4_rspv0", 32'(bus.rsp_valid), 32'h1);
        chk("t4_wav0", 32'(bus.rsp_wav), 32'(lut_fn(10'h3FF)));
        bus.req_valid = '0;
        cyc("t4c");
        chk("t4_rspv1", 32'(bus.rsp_valid), 32'h1);
        chk("t4_wav1", 32'(bus.rsp_wav), 32'(lut_fn(10'h000)));
        chk("t4_hold", 32'(lut_phi), 32'h000);
        cyc("t4d");

        // 5: reset right after an accept drops the response
        do_reset();
        bus.req_valid = 4'b0001;
        bus.req_phi   = {10'd4, 10'd3, 10'd2, 10'd1};
        cyc("t5pre");
        bus.req_valid = 4'b0010;
        cyc("t5a");
        rst           = 1'b1;
        bus.req_valid = 4'b0011;
        #1;
        chk("t5_rst_ready", 32'(bus.req_ready), 32'h0);
        tick();
        rst = 1'b0;
        mreset();
        chk("t5_rspv", 32'(bus.rsp_valid), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);
        #1;
        chk("t5_ptr0", 32'(bus.req_ready), 32'h1);
        cyc("t5b");
        chk("t5_norsp", 32'(bus.rsp_valid), 32'h0);
        bus.req_valid = '0;
        cyc("t5c");
        cyc("t5d");
        cyc("t5e");

        // 6: random 30% traffic against the reference model
        do_reset();
        n_acc = 0;
        n_rsp = 0;
        v     = '0;
        for (int k = 0; k < 300; k++) begin
            bus.req_valid = v;
            cyc("t6");
            for (int i = 0; i < 4; i++) begin
                if (last_g[i] || !v[i]) begin
                    v[i] = ($urandom_range(99) < 30);
                    if (v[i]) bus.req_phi[i*10 +: 10] = 10'($urandom);
                end
            end
        end
        bus.req_valid = '0;
        cyc("t6d0");
        cyc("t6d1");
        cyc("t6d2");
        chk("t6_acc_rsp", 32'(n_rsp), 32'(n_acc));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
